uart_tx: RTL and testbench
==========================

// Module: uart_tx
//
// PURPOSE
// - UART serialiser directly downstream of the character transmit stage. Accepts one byte
//   per uart_en_i/uart_ready_o handshake and drives an 8N1 (or 8N2) frame on tx_o.
// - uart_ready_o is the flow control seen by the character stage. It drops for the whole
//   frame and rises again when the last stop bit completes.
//
// PARAMETERS
// - CLKS_PER_BIT  default 868  clk_i cycles per bit (100 MHz / 115200). Legal range >= 2.
// - STOP_BITS     default 1    number of stop bits. Legal values: 1 or 2.
//
// PORTS
// - clk_i         in   1  single clock; all state updates on its rising edge
// - nrst_i        in   1  reset: asynchronous, active-low
// - uart_en_i     in   1  byte strobe; accepted only in a cycle where uart_ready_o=1
// - uart_data_i   in   8  byte to send; sampled in the accept cycle only
// - uart_ready_o  out  1  1 = idle, able to accept a byte (registered)
// - tx_o          out  1  serial line; idles high (registered)
//
// BEHAVIOUR
// - Reset (nrst_i=0, takes effect immediately, no clock needed):
//   - state=IDLE, uart_ready_o=1, tx_o=1.
//   - Bit counter, baud counter and shift register are all cleared to 0.
// - Accept: a cycle with uart_en_i=1 and uart_ready_o=1.
//   - Edge ending that cycle: shift register <= uart_data_i, baud counter <= 0,
//     state <= START, uart_ready_o <= 0, tx_o <= 0.
// - uart_en_i while uart_ready_o=0 is ignored. No queueing, no error flag.
// - Baud counter: width $clog2(CLKS_PER_BIT).
//   - Counts 0..CLKS_PER_BIT-1 in START, DATA and STOP.
//   - Terminal count ends the current bit and wraps the counter to 0.
// - START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
// - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
//   - tx_o <= shreg[0]; the register shifts right at each bit end.
//   - The 3-bit index wraps 7->0 and the state goes to STOP.
// - STOP: tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles.
//   - The edge ending the last stop cycle sets state <= IDLE and uart_ready_o <= 1.
// - Frame timing: tx_o leaves 1 on the edge after the accept cycle.
//   uart_ready_o=0 for exactly (9+STOP_BITS)*CLKS_PER_BIT cycles.
// - Back-to-back: an accept in the first cycle that uart_ready_o=1 starts the next start
//   bit at once. The line gets no idle gap beyond the stop bits.
// - Handshake guarantee: uart_ready_o is 0 in the cycle after any accept. The upstream
//   wait-for-ready state therefore never sees a stale 1.
// - uart_data_i changes after the accept cycle have no effect on the frame in progress.
// - Reset asserted mid-frame: tx_o returns to 1 at once and the frame is abandoned.
//   After release: uart_ready_o=1, and the next accept sends a full, fresh frame.
// - Unused state encodings recover to IDLE with tx_o=1 and uart_ready_o=1.
//
// TESTING (bench uses CLKS_PER_BIT=4, STOP_BITS=1 unless noted)
// 1. Reset and idle
//    - Assert nrst_i with no clock edge -> tx_o=1 and uart_ready_o=1 immediately.
//    - Hold 20 cycles after release -> both stay high.
// 2. Single byte 0xA5
//    - Accept at cycle T -> uart_ready_o=0 from T+1.
//    - tx_o, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
//    - uart_ready_o=1 again at T+41.
// 3. Back-to-back 0x00 then 0xFF
//    - Second accept in the first ready cycle -> exactly 4 stop cycles between frames.
//    - Decoded bytes: 0x00, 0xFF.
// 4. Ignored strobe and data hold
//    - Pulse uart_en_i with data 0x3C mid-frame -> current frame unchanged, 0x3C never sent.
//    - Change uart_data_i after accept -> frame still carries the latched byte.
// 5. Reset mid-frame
//    - Drop nrst_i during data bit 3 -> tx_o=1 within the same cycle.
//    - After release, send 0x55 -> one clean frame decoded as 0x55.
// 6. STOP_BITS=2 and CLKS_PER_BIT=2
//    - Send 0x81 -> stop high for 4 cycles.
//    - uart_ready_o low for 22 cycles; decoded byte 0x81.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per uart_en_i/uart_ready_o handshake
// into a start bit, eight data bits LSB first, and STOP_BITS stop bits.
// Both outputs are registered; uart_ready_o stays low for the whole frame.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       uart_en_i,
    input  logic [7:0] uart_data_i,
    output logic       uart_ready_o,
    output logic       tx_o
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bitIdx;
    logic [7:0]        r_shreg;
    logic              r_ready;
    logic              r_tx;

    state_t            w_state;
    logic [BAUD_W-1:0] w_baud;
    logic [2:0]        w_bitIdx;
    logic [7:0]        w_shreg;
    logic              w_ready;
    logic              w_tx;
    logic              w_baudDone;

    assign w_baudDone   = (r_baud == BAUD_LAST);
    assign uart_ready_o = r_ready;
    assign tx_o         = r_tx;

    // Next-state and next-output logic; each bit ends when the baud counter hits its terminal count.
    always_comb begin
        w_state  = r_state;
        w_baud   = r_baud;
        w_bitIdx = r_bitIdx;
        w_shreg  = r_shreg;
        w_ready  = r_ready;
        w_tx     = r_tx;
        case (r_state)
            IDLE: begin
                w_tx     = 1'b1;
                w_ready  = 1'b1;
                w_baud   = '0;
                w_bitIdx = '0;
                if (uart_en_i && r_ready) begin
                    w_shreg = uart_data_i;
                    w_state = START;
                    w_ready = 1'b0;
                    w_tx    = 1'b0;
                end
            end
            START: begin
                if (w_baudDone) begin
                    w_baud   = '0;
                    w_bitIdx = '0;
                    w_state  = DATA;
                    w_tx     = r_shreg[0];
                    w_shreg  = {1'b0, r_shreg[7:1]};
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end
            DATA: begin
                if (w_baudDone) begin
                    w_baud = '0;
                    if (r_bitIdx == 3'd7) begin
                        w_bitIdx = '0;
                        w_state  = STOP;
                        w_tx     = 1'b1;
                    end else begin
                        w_bitIdx = r_bitIdx + 3'd1;
                        w_tx     = r_shreg[0];
                        w_shreg  = {1'b0, r_shreg[7:1]};
                    end
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end
            STOP: begin
                w_tx = 1'b1;
                if (w_baudDone) begin
                    w_baud = '0;
                    if (r_bitIdx == STOP_LAST) begin
                        w_bitIdx = '0;
                        w_state  = IDLE;
                        w_ready  = 1'b1;
                    end else begin
                        w_bitIdx = r_bitIdx + 3'd1;
                    end
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end
            default: begin
                w_state  = IDLE;
                w_tx     = 1'b1;
                w_ready  = 1'b1;
                w_baud   = '0;
                w_bitIdx = '0;
            end
        endcase
    end

    // State and datapath registers; reset idles the line high and abandons any frame.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_shreg  <= '0;
            r_ready  <= 1'b1;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_state;
            r_baud   <= w_baud;
            r_bitIdx <= w_bitIdx;
            r_shreg  <= w_shreg;
            r_ready  <= w_ready;
            r_tx     <= w_tx;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: a cycle-level line model built from the frame format,
// a behavioural UART receiver, table-driven bytes, random bytes and hand-written
// corner cases. Two DUTs: 4 clocks/bit with 1 stop, and 2 clocks/bit with 2 stops.
module tb_uart_tx;

    localparam int CPB1  = 4;
    localparam int STOP1 = 1;
    localparam int CPB2  = 2;
    localparam int STOP2 = 2;

    logic       clk;
    logic       rstN;
    logic       en1, en2;
    logic [7:0] data1, data2;
    logic       ready1, ready2;
    logic       tx1, tx2;

    int checks = 0;
    int passes = 0;
    bit checkOn = 0;

    logic       expQ1 [$];
    logic       expQ2 [$];
    logic [7:0] rxQ   [$];
    logic [7:0] sentQ [$];

    typedef struct {
        logic [7:0] data;
        int         gap;
        bit         strobe;
        logic [7:0] expByte;
    } vec_t;

    vec_t vecs [5];

    uart_tx #(.CLKS_PER_BIT(CPB1), .STOP_BITS(STOP1)) dut1 (
        .clk_i(clk), .nrst_i(rstN), .uart_en_i(en1), .uart_data_i(data1),
        .uart_ready_o(ready1), .tx_o(tx1)
    );

    uart_tx #(.CLKS_PER_BIT(CPB2), .STOP_BITS(STOP2)) dut2 (
        .clk_i(clk), .nrst_i(rstN), .uart_en_i(en2), .uart_data_i(data2),
        .uart_ready_o(ready2), .tx_o(tx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    // Expected line levels for one frame: start, data LSB first, stop bits.
    function automatic void addFrame(input int which, input logic [7:0] d);
        int   cpb;
        int   stops;
        logic lvl;
        cpb   = (which == 1) ? CPB1 : CPB2;
        stops = (which == 1) ? STOP1 : STOP2;
        for (int b = 0; b < 10 + stops - 1; b++) begin
            if (b == 0) lvl = 1'b0;
            else if (b <= 8) lvl = d[b-1];
            else lvl = 1'b1;
            for (int c = 0; c < cpb; c++) begin
                if (which == 1) expQ1.push_back(lvl);
                else expQ2.push_back(lvl);
            end
        end
    endfunction

    // Reference model: a DUT is ready exactly when its expected-line queue is empty.
    initial forever begin
        @(posedge clk);
        if (!rstN) begin
            expQ1.delete();
            expQ2.delete();
        end else begin
            if (expQ1.size() != 0) void'(expQ1.pop_front());
            else if (en1 === 1'b1) addFrame(1, data1);
            if (expQ2.size() != 0) void'(expQ2.pop_front());
            else if (en2 === 1'b1) addFrame(2, data2);
        end
    end

    // Per-cycle comparison against the model plus a behavioural receiver on DUT1's line.
    initial begin : monitor
        int         rxCnt;
        logic [7:0] rxByte;
        rxCnt  = -1;
        rxByte = '0;
        forever begin
            @(negedge clk);
            if (checkOn) begin
                if (!rstN) begin
                    checkOutput("tx1 in reset", tx1, 1);
                    checkOutput("ready1 in reset", ready1, 1);
                end else begin
                    checkOutput("tx1 line", tx1, (expQ1.size() != 0) ? expQ1[0] : 1'b1);
                    checkOutput("ready1", ready1, (expQ1.size() == 0) ? 1 : 0);
                    checkOutput("tx2 line", tx2, (expQ2.size() != 0) ? expQ2[0] : 1'b1);
                    checkOutput("ready2", ready2, (expQ2.size() == 0) ? 1 : 0);
                end
            end
            if (!rstN) begin
                rxCnt = -1;
            end else if (rxCnt < 0) begin
                if (tx1 === 1'b0) rxCnt = 0;
            end else begin
                rxCnt++;
                if (rxCnt >= CPB1 && rxCnt < 9 * CPB1 && (rxCnt % CPB1) == CPB1 / 2)
                    rxByte[rxCnt / CPB1 - 1] = tx1;
                if (rxCnt == 9 * CPB1 + CPB1 / 2) begin
                    if (tx1 === 1'b1) rxQ.push_back(rxByte);
                    rxCnt = -1;
                end
            end
        end
    end

    // Waits (bounded) for ready, idles gap cycles, then strobes one byte in.
    task automatic applyStimulus(input int which, input logic [7:0] d, input int gap);
        int waited;
        waited = 0;
        while (((which == 1) ? ready1 : ready2) !== 1'b1 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("ready before send", (which == 1) ? ready1 : ready2, 1);
        repeat (gap) begin @(posedge clk); #1; end
        if (which == 1) begin en1 = 1'b1; data1 = d; end
        else begin en2 = 1'b1; data2 = d; end
        @(posedge clk); #1;
        if (which == 1) begin en1 = 1'b0; data1 = ~d; end
        else begin en2 = 1'b0; data2 = ~d; end
        checkOutput("ready low after accept", (which == 1) ? ready1 : ready2, 0);
    endtask

    task automatic waitIdle1();
        int waited;
        waited = 0;
        while (ready1 !== 1'b1 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("idle reached", ready1, 1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Captures a frame right after accept until ready returns.
    task automatic measureFrame(input int which, output int lowCycles, output logic [7:0] decoded,
                                output int stopHigh, output logic startLow);
        int   cpb;
        int   k;
        logic s [0:255];
        cpb = (which == 1) ? CPB1 : CPB2;
        k   = 0;
        for (int i = 0; i < 256; i++) s[i] = 1'b1;
        while (k < 200) begin
            @(negedge clk);
            if (((which == 1) ? ready1 : ready2) === 1'b1) break;
            s[k] = (which == 1) ? tx1 : tx2;
            k++;
        end
        lowCycles = k;
        for (int i = 0; i < 8; i++) decoded[i] = s[cpb * (1 + i) + cpb / 2];
        startLow = s[cpb / 2];
        stopHigh = 0;
        for (int i = 9 * cpb; i < k; i++) if (s[i] === 1'b1) stopHigh++;
        @(posedge clk); #1;
    endtask

    task automatic checkDecoded(input string name);
        checkOutput({name, " count"}, rxQ.size(), sentQ.size());
        for (int i = 0; i < rxQ.size() && i < sentQ.size(); i++)
            checkOutput({name, " byte"}, rxQ[i], sentQ[i]);
        rxQ.delete();
        sentQ.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int         low;
        int         stopHi;
        logic [7:0] dec;
        logic       stLow;
        logic [7:0] rnd;
        bit         strb;

        vecs[0] = '{8'h00, 2, 1'b0, 8'h00};
        vecs[1] = '{8'hFF, 0, 1'b0, 8'hFF};
        vecs[2] = '{8'h12, 1, 1'b1, 8'h12};
        vecs[3] = '{8'h80, 0, 1'b1, 8'h80};
        vecs[4] = '{8'h7E, 3, 1'b0, 8'h7E};

        rstN  = 1'b1;
        en1   = 1'b0;
        en2   = 1'b0;
        data1 = 8'h00;
        data2 = 8'h00;

        $display("[TB] reset without clock edge");
        #2 rstN = 1'b0;
        #1;
        checkOutput("async reset tx1", tx1, 1);
        checkOutput("async reset ready1", ready1, 1);
        checkOutput("async reset tx2", tx2, 1);
        checkOutput("async reset ready2", ready2, 1);
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        checkOn = 1;
        repeat (20) begin @(posedge clk); #1; end
        checkOutput("idle tx1 after 20", tx1, 1);
        checkOutput("idle ready1 after 20", ready1, 1);

        $display("[TB] single byte 0xA5");
        applyStimulus(1, 8'hA5, 0);
        measureFrame(1, low, dec, stopHi, stLow);
        checkOutput("A5 ready low cycles", low, 40);
        checkOutput("A5 decoded", dec, 8'hA5);
        checkOutput("A5 start bit", stLow, 0);
        checkOutput("A5 stop high cycles", stopHi, 4);
        rxQ.delete();

        $display("[TB] table vectors");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, vecs[i].data, vecs[i].gap);
            sentQ.push_back(vecs[i].expByte);
            if (vecs[i].strobe) begin
                repeat (10) begin @(posedge clk); #1; end
                en1   = 1'b1;
                data1 = 8'h3C;
                @(posedge clk); #1;
                en1   = 1'b0;
            end
        end
        waitIdle1();
        checkDecoded("table");

        $display("[TB] random bytes");
        for (int i = 0; i < 20; i++) begin
            rnd  = 8'($urandom);
            strb = 1'($urandom_range(0, 1));
            applyStimulus(1, rnd, $urandom_range(0, 2));
            sentQ.push_back(rnd);
            if (strb) begin
                repeat ($urandom_range(1, 30)) begin @(posedge clk); #1; end
                en1   = 1'b1;
                data1 = 8'($urandom);
                @(posedge clk); #1;
                en1   = 1'b0;
            end
        end
        waitIdle1();
        checkDecoded("random");

        $display("[TB] reset mid-frame");
        applyStimulus(1, 8'hF0, 0);
        repeat (16) begin @(posedge clk); #1; end
        checkOutput("data bit 3 before reset", tx1, 0);
        #2 rstN = 1'b0;
        #1;
        checkOutput("tx1 high on reset", tx1, 1);
        checkOutput("ready1 high on reset", ready1, 1);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        rxQ.delete();
        sentQ.delete();
        applyStimulus(1, 8'h55, 1);
        sentQ.push_back(8'h55);
        waitIdle1();
        checkDecoded("after reset");

        $display("[TB] two stop bits, two clocks per bit");
        applyStimulus(2, 8'h81, 0);
        measureFrame(2, low, dec, stopHi, stLow);
        checkOutput("81 ready low cycles", low, 22);
        checkOutput("81 decoded", dec, 8'h81);
        checkOutput("81 start bit", stLow, 0);
        checkOutput("81 stop high cycles", stopHi, 4);
        repeat (3) begin @(posedge clk); #1; end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
